// File: rtl/temp_sample_ctrl.sv
// Periodic sampler wrapped around i2c_fsm: requests reads, averages 2^AVG_LOG2 temperature codes, flags timeouts.
// Build option TEMP_MINMAX_EN adds running signed min/max of the published averages.
module temp_sample_ctrl #(
  parameter int PERIOD   = 1000000,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 65535
) (
  input  logic        clk,
  input  logic        arst,
  input  logic        rst,
  input  logic        enable,
  output logic        start_o,
  input  logic        done_i,
  input  logic [7:0]  msb_i,
  input  logic [7:0]  lsb_i,
  output logic [11:0] temp_o,
  output logic        temp_valid_o,
  output logic        timeout_o,
  output logic [11:0] temp_min_o,
  output logic [11:0] temp_max_o
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int NW = AVG_LOG2 + 1;
  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD - 1);
  localparam logic [TW-1:0] TIMEOUT_HIT = TW'(TIMEOUT);
  localparam logic [NW-1:0] N_FULL      = NW'(1 << AVG_LOG2);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] REQ         = 3'd1;
  localparam logic [2:0] WAIT_DONE   = 3'd2;
  localparam logic [2:0] ACC         = 3'd3;
  localparam logic [2:0] OUT         = 3'd4;
  localparam logic [2:0] WAIT_PERIOD = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [PW-1:0]        per_cnt_q, per_cnt_d;
  logic [TW-1:0]        to_cnt_q, to_cnt_d;
  logic signed [11:0]   raw_q, raw_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [NW-1:0]        n_q, n_d;
  logic [11:0]          temp_q, temp_d;
  logic                 temp_valid_q, temp_valid_d;
  logic                 timeout_q, timeout_d;

  logic signed [AW-1:0] raw_ext;
  logic signed [11:0]   avg;
  logic [NW-1:0]        n_inc;
  logic                 unused_lsb;

  assign raw_ext    = raw_q;
  assign avg        = 12'(acc_q >>> AVG_LOG2);
  assign n_inc      = n_q + 1'b1;
  assign unused_lsb = ^lsb_i[3:0];

  always_comb begin
    state_d      = state_q;
    // Counts cycles since the last REQ and saturates, so a slow transaction restarts immediately.
    per_cnt_d    = (per_cnt_q < PERIOD_LAST) ? per_cnt_q + 1'b1 : per_cnt_q;
    to_cnt_d     = to_cnt_q;
    raw_d        = raw_q;
    acc_d        = acc_q;
    n_d          = n_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    timeout_d    = timeout_q;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        n_d   = '0;
        if (enable) state_d = REQ;
      end
      REQ: begin
        per_cnt_d = PW'(1);
        to_cnt_d  = TW'(1);
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        // done_i takes priority over a timeout landing in the same cycle
        if (done_i) begin
          raw_d   = {msb_i, lsb_i[7:4]};
          state_d = ACC;
        end else if (to_cnt_q >= TIMEOUT_HIT) begin
          timeout_d = 1'b1;
          state_d   = WAIT_PERIOD;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      ACC: begin
        acc_d   = acc_q + raw_ext;
        n_d     = n_inc;
        state_d = (n_inc == N_FULL) ? OUT : WAIT_PERIOD;
      end
      OUT: begin
        temp_d       = avg;
        temp_valid_d = 1'b1;
        acc_d        = '0;
        n_d          = '0;
        state_d      = WAIT_PERIOD;
      end
      WAIT_PERIOD: begin
        if (!enable) state_d = IDLE;
        else if (per_cnt_q >= PERIOD_LAST) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      to_cnt_q     <= '0;
      raw_q        <= '0;
      acc_q        <= '0;
      n_q          <= '0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (rst) begin
      state_q      <= IDLE;
      per_cnt_q    <= '0;
      to_cnt_q     <= '0;
      raw_q        <= '0;
      acc_q        <= '0;
      n_q          <= '0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_cnt_q    <= per_cnt_d;
      to_cnt_q     <= to_cnt_d;
      raw_q        <= raw_d;
      acc_q        <= acc_d;
      n_q          <= n_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign start_o      = (state_q == REQ);
  assign temp_o       = temp_q;
  assign temp_valid_o = temp_valid_q;
  assign timeout_o    = timeout_q;

`ifdef TEMP_MINMAX_EN
  logic signed [11:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (state_q == OUT) begin
      if (avg < min_q) min_d = avg;
      if (avg > max_q) max_d = avg;
    end
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      min_q <= 12'h7FF;
      max_q <= 12'h800;
    end else if (rst) begin
      min_q <= 12'h7FF;
      max_q <= 12'h800;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign temp_min_o = min_q;
  assign temp_max_o = max_q;
`else
  assign temp_min_o = 12'h7FF;
  assign temp_max_o = 12'h800;
`endif

endmodule

// File: tb/tb_temp_sample_ctrl.sv
// Bench for temp_sample_ctrl: an i2c_fsm stand-in answers each start 5 cycles later from a sample queue;
// averages are predicted from the raw codes with plain integer arithmetic.
module tb_temp_sample_ctrl;
  localparam int PERIOD   = 20;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 50;
`ifdef TEMP_MINMAX_EN
  localparam bit MINMAX = 1'b1;
`else
  localparam bit MINMAX = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        done_i = 1'b0;
  logic [7:0]  msb_i = 8'h00;
  logic [7:0]  lsb_i = 8'h00;
  logic        start_o, temp_valid_o, timeout_o;
  logic [11:0] temp_o, temp_min_o, temp_max_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_min = 2047;
  int exp_max = -2048;

  typedef struct {
    logic [7:0] msb;
    logic [7:0] lsb;
    bit         mute;
  } sample_t;

  sample_t     resp_q[$];
  sample_t     cur;
  int          start_cyc[$];
  int          valid_cyc[$];
  logic [11:0] valid_val[$];
  int          to_rise[$];
  logic        to_prev = 1'b0;

  temp_sample_ctrl #(.PERIOD(PERIOD), .AVG_LOG2(AVG_LOG2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .arst(arst), .rst(rst), .enable(enable), .start_o(start_o),
    .done_i(done_i), .msb_i(msb_i), .lsb_i(lsb_i), .temp_o(temp_o),
    .temp_valid_o(temp_valid_o), .timeout_o(timeout_o),
    .temp_min_o(temp_min_o), .temp_max_o(temp_max_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start_o) start_cyc.push_back(cyc);
    if (temp_valid_o) begin
      valid_cyc.push_back(cyc);
      valid_val.push_back(temp_o);
    end
    if (timeout_o && !to_prev) to_rise.push_back(cyc);
    to_prev <= timeout_o;
  end

  // i2c_fsm stand-in: done 5 cycles after start, unless the queued entry is muted
  initial begin
    forever begin
      @(posedge clk); #1;
      if (start_o) begin
        if (resp_q.size() > 0) cur = resp_q.pop_front();
        else begin
          cur.msb = 8'h00; cur.lsb = 8'h00; cur.mute = 1'b1;
        end
        if (!cur.mute) begin
          repeat (5) @(posedge clk);
          #1; done_i = 1'b1; msb_i = cur.msb; lsb_i = cur.lsb;
          @(posedge clk);
          #1; done_i = 1'b0; msb_i = 8'h00; lsb_i = 8'h00;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int raw_of(input logic [7:0] m, input logic [7:0] l);
    logic signed [11:0] r;
    r = {m, l[7:4]};
    return int'(r);
  endfunction

  function automatic int floor4(input int s);
    int q;
    q = s / 4;
    if (s < 0 && (s % 4) != 0) q = q - 1;
    return q;
  endfunction

  function automatic void push(input logic [7:0] m, input logic [7:0] l, input bit mute);
    sample_t s;
    s.msb = m; s.lsb = l; s.mute = mute;
    resp_q.push_back(s);
  endfunction

  function automatic int push_rand(input bit positive);
    logic [7:0] m, l;
    m = positive ? 8'($urandom_range(1, 127)) : 8'($urandom);
    l = 8'($urandom);
    push(m, l, 1'b0);
    return raw_of(m, l);
  endfunction

  function automatic void note_avg(input int a);
    if (a < exp_min) exp_min = a;
    if (a > exp_max) exp_max = a;
  endfunction

  function automatic void clear_mon();
    start_cyc.delete(); valid_cyc.delete(); valid_val.delete(); to_rise.delete();
  endfunction

  task automatic wait_valid(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (valid_cyc.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #1;
      if (start_cyc.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_batch(input int n_valid, input int limit, output bit ok);
    enable = 1'b1;
    wait_valid(n_valid, limit, ok);
    enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    enable = 1'b0; arst = 1'b0; #3;
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", start_o); end
    total++; if (temp_o !== 12'h000) begin bad++; $display("FAIL reset_temp got=%h want=000", temp_o); end
    total++; if (temp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", temp_valid_o); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_o); end
    total++; if (temp_min_o !== 12'h7FF) begin bad++; $display("FAIL reset_min got=%h want=7ff", temp_min_o); end
    total++; if (temp_max_o !== 12'h800) begin bad++; $display("FAIL reset_max got=%h want=800", temp_max_o); end
    repeat (2) @(posedge clk);
    #2 arst = 1'b1;
    clear_mon();
    repeat (5) @(negedge clk);
    total++; if (start_cyc.size() != 0) begin bad++; $display("FAIL reset_idle_starts got=%0d want=0", start_cyc.size()); end
    exp_min = 2047; exp_max = -2048;
    $display("reset: checked reset values and idle with enable=0");
  endtask

  task automatic test_positive_avg();
    bit ok;
    clear_mon();
    push(8'h19, 8'h00, 1'b0); push(8'h19, 8'h00, 1'b0);
    push(8'h19, 8'h40, 1'b0); push(8'h19, 8'h40, 1'b0);
    run_batch(1, 200, ok);
    total++; if (!ok) begin bad++; $display("FAIL t1_valid_seen got=0 want=1"); end
    total++; if (valid_cyc.size() != 1) begin bad++; $display("FAIL t1_valid_count got=%0d want=1", valid_cyc.size()); end
    total++; if (start_cyc.size() != 4) begin bad++; $display("FAIL t1_start_count got=%0d want=4", start_cyc.size()); end
    if (ok && start_cyc.size() >= 4) begin
      total++; if (valid_val[0] !== 12'h192) begin bad++; $display("FAIL t1_temp got=%h want=192", valid_val[0]); end
      total++; if (valid_cyc[0] - start_cyc[3] != 8) begin bad++; $display("FAIL t1_latency got=%0d want=8", valid_cyc[0] - start_cyc[3]); end
      for (int i = 1; i < 4; i++) begin
        total++;
        if (start_cyc[i] - start_cyc[i-1] != PERIOD) begin
          bad++; $display("FAIL t1_period[%0d] got=%0d want=%0d", i, start_cyc[i] - start_cyc[i-1], PERIOD);
        end
      end
      $display("t1: temp_o=%h at cycle %0d", valid_val[0], valid_cyc[0]);
    end
    note_avg(402);
  endtask

  task automatic test_negative_avg();
    bit ok;
    int expv;
    clear_mon();
    push(8'hFF, 8'h00, 1'b0); push(8'hFF, 8'h00, 1'b0);
    push(8'hFF, 8'hF0, 1'b0); push(8'hFF, 8'hE0, 1'b0);
    expv = floor4(-16 - 16 - 1 - 2);
    run_batch(1, 200, ok);
    total++; if (!ok || valid_val.size() != 1) begin bad++; $display("FAIL t2_valid_count got=%0d want=1", valid_val.size()); end
    if (ok) begin
      total++; if (valid_val[0] !== 12'hFF7) begin bad++; $display("FAIL t2_temp got=%h want=ff7", valid_val[0]); end
      $display("t2: temp_o=%h", valid_val[0]);
    end
    note_avg(expv);
    total++; if (temp_min_o !== (MINMAX ? exp_min[11:0] : 12'h7FF)) begin bad++; $display("FAIL t6_min got=%h want=%h", temp_min_o, MINMAX ? exp_min[11:0] : 12'h7FF); end
    total++; if (temp_max_o !== (MINMAX ? exp_max[11:0] : 12'h800)) begin bad++; $display("FAIL t6_max got=%h want=%h", temp_max_o, MINMAX ? exp_max[11:0] : 12'h800); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int sum[3];
    clear_mon();
    for (int b = 0; b < 3; b++) begin
      sum[b] = 0;
      for (int k = 0; k < 4; k++) sum[b] += push_rand(1'b0);
    end
    run_batch(3, 400, ok);
    total++; if (!ok || valid_val.size() != 3) begin bad++; $display("FAIL b2b_valid_count got=%0d want=3", valid_val.size()); end
    for (int b = 0; b < 3; b++) begin
      if (b < valid_val.size()) begin
        total++;
        if (valid_val[b] !== 12'(floor4(sum[b]))) begin
          bad++; $display("FAIL b2b_temp[%0d] got=%h want=%h", b, valid_val[b], 12'(floor4(sum[b])));
        end
        $display("b2b[%0d]: temp_o=%h sum=%0d", b, valid_val[b], sum[b]);
      end
      note_avg(floor4(sum[b]));
    end
    if (start_cyc.size() == 12) begin
      total++; if (start_cyc[11] - start_cyc[0] != 11 * PERIOD) begin bad++; $display("FAIL b2b_span got=%0d want=%0d", start_cyc[11] - start_cyc[0], 11 * PERIOD); end
    end else begin
      total++; bad++; $display("FAIL b2b_start_count got=%0d want=12", start_cyc.size());
    end
    total++; if (temp_min_o !== (MINMAX ? exp_min[11:0] : 12'h7FF)) begin bad++; $display("FAIL b2b_min got=%h want=%h", temp_min_o, MINMAX ? exp_min[11:0] : 12'h7FF); end
    total++; if (temp_max_o !== (MINMAX ? exp_max[11:0] : 12'h800)) begin bad++; $display("FAIL b2b_max got=%h want=%h", temp_max_o, MINMAX ? exp_max[11:0] : 12'h800); end
  endtask

  task automatic test_timeout();
    bit ok;
    int sum;
    clear_mon();
    sum = push_rand(1'b0);
    sum += push_rand(1'b0);
    push(8'h00, 8'h00, 1'b1);
    sum += push_rand(1'b0);
    sum += push_rand(1'b0);
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL t3_timeout_before got=%b want=0", timeout_o); end
    run_batch(1, 400, ok);
    total++; if (!ok || valid_val.size() != 1) begin bad++; $display("FAIL t3_valid_count got=%0d want=1", valid_val.size()); end
    if (ok) begin
      total++; if (valid_val[0] !== 12'(floor4(sum))) begin bad++; $display("FAIL t3_temp got=%h want=%h", valid_val[0], 12'(floor4(sum))); end
    end
    note_avg(floor4(sum));
    total++; if (start_cyc.size() != 5) begin bad++; $display("FAIL t3_start_count got=%0d want=5", start_cyc.size()); end
    total++; if (to_rise.size() != 1) begin bad++; $display("FAIL t3_timeout_rises got=%0d want=1", to_rise.size()); end
    if (start_cyc.size() >= 4 && to_rise.size() >= 1) begin
      total++;
      if (to_rise[0] - start_cyc[2] < TIMEOUT || to_rise[0] - start_cyc[2] > TIMEOUT + 1) begin
        bad++; $display("FAIL t3_timeout_time got=%0d want=%0d..%0d", to_rise[0] - start_cyc[2], TIMEOUT, TIMEOUT + 1);
      end
      total++;
      if (start_cyc[3] - start_cyc[2] < TIMEOUT + 1 || start_cyc[3] - start_cyc[2] > TIMEOUT + 3) begin
        bad++; $display("FAIL t3_restart got=%0d want=%0d..%0d", start_cyc[3] - start_cyc[2], TIMEOUT + 1, TIMEOUT + 3);
      end
      $display("t3: timeout at +%0d, next start at +%0d", to_rise[0] - start_cyc[2], start_cyc[3] - start_cyc[2]);
    end
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL t3_sticky got=%b want=1", timeout_o); end
  endtask

  task automatic test_sync_reset();
    @(negedge clk);
    rst = 1'b1; #1;
    total++; if (timeout_o !== 1'b1) begin bad++; $display("FAIL srst_is_sync got=%b want=1", timeout_o); end
    @(posedge clk); #1;
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL srst_timeout got=%b want=0", timeout_o); end
    total++; if (temp_o !== 12'h000) begin bad++; $display("FAIL srst_temp got=%h want=000", temp_o); end
    total++; if (temp_min_o !== 12'h7FF) begin bad++; $display("FAIL srst_min got=%h want=7ff", temp_min_o); end
    total++; if (temp_max_o !== 12'h800) begin bad++; $display("FAIL srst_max got=%h want=800", temp_max_o); end
    @(negedge clk);
    rst = 1'b0;
    exp_min = 2047; exp_max = -2048;
    $display("srst: outputs back to reset values");
  endtask

  task automatic test_enable_drop();
    bit ok;
    int sum;
    clear_mon();
    push(8'h7F, 8'h00, 1'b0); push(8'h7F, 8'h00, 1'b0);
    enable = 1'b1;
    wait_start(2, 100, ok);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (!ok || start_cyc.size() != 2) begin bad++; $display("FAIL t4_starts_before_drop got=%0d want=2", start_cyc.size()); end
    total++; if (valid_cyc.size() != 0) begin bad++; $display("FAIL t4_no_valid got=%0d want=0", valid_cyc.size()); end
    clear_mon();
    sum = 0;
    for (int k = 0; k < 4; k++) sum += push_rand(1'b1);
    run_batch(1, 200, ok);
    total++; if (!ok || valid_val.size() != 1) begin bad++; $display("FAIL t4_valid_count got=%0d want=1", valid_val.size()); end
    if (ok) begin
      total++; if (valid_val[0] !== 12'(floor4(sum))) begin bad++; $display("FAIL t4_temp got=%h want=%h", valid_val[0], 12'(floor4(sum))); end
      $display("t4: fresh average temp_o=%h", valid_val[0]);
    end
    total++; if (start_cyc.size() != 4) begin bad++; $display("FAIL t4_start_count got=%0d want=4", start_cyc.size()); end
  endtask

  task automatic test_arst_mid();
    bit ok;
    int sum;
    clear_mon();
    push(8'h12, 8'h30, 1'b0);
    enable = 1'b1;
    wait_start(1, 50, ok);
    total++; if (!ok) begin bad++; $display("FAIL t5_first_start got=0 want=1"); end
    @(posedge clk); @(posedge clk);
    #2 arst = 1'b0; enable = 1'b0;
    #1;
    total++; if (temp_o !== 12'h000) begin bad++; $display("FAIL t5_temp got=%h want=000", temp_o); end
    total++; if (start_o !== 1'b0) begin bad++; $display("FAIL t5_start got=%b want=0", start_o); end
    total++; if (temp_min_o !== 12'h7FF || temp_max_o !== 12'h800) begin bad++; $display("FAIL t5_minmax got=%h/%h want=7ff/800", temp_min_o, temp_max_o); end
    @(posedge clk);
    #2 arst = 1'b1;
    exp_min = 2047; exp_max = -2048;
    repeat (30) @(negedge clk);
    total++; if (valid_cyc.size() != 0) begin bad++; $display("FAIL t5_late_done got=%0d want=0", valid_cyc.size()); end
    total++; if (start_cyc.size() != 1) begin bad++; $display("FAIL t5_no_restart got=%0d want=1", start_cyc.size()); end
    total++; if (timeout_o !== 1'b0) begin bad++; $display("FAIL t5_timeout got=%b want=0", timeout_o); end
    clear_mon();
    sum = 0;
    for (int k = 0; k < 4; k++) sum += push_rand(1'b0);
    run_batch(1, 200, ok);
    total++; if (!ok || valid_val.size() != 1) begin bad++; $display("FAIL t5_valid_count got=%0d want=1", valid_val.size()); end
    if (ok) begin
      total++; if (valid_val[0] !== 12'(floor4(sum))) begin bad++; $display("FAIL t5_temp_after got=%h want=%h", valid_val[0], 12'(floor4(sum))); end
      $display("t5: average after reset temp_o=%h", valid_val[0]);
    end
  endtask

  initial begin
    test_reset();
    test_positive_avg();
    test_negative_avg();
    test_back_to_back();
    test_timeout();
    test_sync_reset();
    test_enable_drop();
    test_arst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
